// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions.
// Contents: machine word width, the reset PC, the bubble instruction, and the
// IF/ID bundle type that both fetch and decode use.
package rv32_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    logic  valid;
    word_t pc;
    word_t pc4;
    word_t inst;
  } ifid_t;

  // An empty IF/ID slot. It is used on reset and on a flush.
  function automatic ifid_t ifid_bubble(input word_t nop);
    ifid_t b;
    b.valid = 1'b0;
    b.pc    = '0;
    b.pc4   = '0;
    b.inst  = nop;
    return b;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle between the fetch stage, the instruction memory port, and decode.
//   imem_req/imem_addr   fetch request and word-aligned address (fetch -> mem)
//   imem_ready           grant; a request is taken when req && ready
//   imem_rdata           data, valid exactly one cycle after the grant
//   id_valid/pc/pc4/inst IF/ID pipeline register contents (fetch -> decode)
interface if_fetch_unit_if;
  import rv32_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ready;
  word_t imem_rdata;
  logic  id_valid;
  word_t id_pc;
  word_t id_pc4;
  word_t id_inst;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    output id_valid, id_pc, id_pc4, id_inst
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    input  id_valid, id_pc, id_pc4, id_inst
  );
endinterface

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetch response that arrives while decode
// is stalled.
//   clk, rst   core clock, synchronous active-high reset
//   clear_i    drop the contents (flush); this wins over load/drain
//   load_i     capture inst_i/pc_i and mark full
//   drain_i    contents consumed this cycle; mark empty
//   full_o     holds a valid entry
//   inst_o     held instruction word
//   pc_o       PC of the held instruction
module if_skid_buffer
  import rv32_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear_i,
  input  logic  load_i,
  input  logic  drain_i,
  input  word_t inst_i,
  input  word_t pc_i,
  output logic  full_o,
  output word_t inst_o,
  output word_t pc_o
);

  logic  full_q, full_d;
  word_t inst_q, inst_d;
  word_t pc_q, pc_d;

  always_comb begin
    full_d = full_q;
    inst_d = inst_q;
    pc_d   = pc_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d = 1'b1;
      inst_d = inst_i;
      pc_d   = pc_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      inst_q <= '0;
      pc_q   <= '0;
    end else begin
      full_q <= full_d;
      inst_q <= inst_d;
      pc_q   <= pc_d;
    end
  end

  assign full_o = full_q;
  assign inst_o = inst_q;
  assign pc_o   = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32 instruction-fetch stage. It owns the fetch PC and keeps at most one
// request outstanding to instruction memory. It fills the IF/ID register and
// handles decode stalls, EX redirects with flush, and grant back-pressure. A
// response that lands while decode is stalled is parked in a 1-entry skid.
//   clk, rst           core clock, synchronous active-high reset
//   stall_i            hold IF/ID and the fetch PC
//   redirect_valid_i   taken branch/jump; flushes IF/ID (overrides stall)
//   redirect_target_i  new PC, low two bits ignored
//   bus                imem request/response and IF/ID outputs
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = rv32_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = rv32_pkg::NOP_INST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   redirect_valid_i,
  input  logic [31:0]            redirect_target_i,
  if_fetch_unit_if.master        bus
);
  import rv32_pkg::*;

  word_t fetch_pc_q, fetch_pc_d;
  word_t pend_pc_q, pend_pc_d;
  logic  pend_q, pend_d;
  logic  pend_discard_q, pend_discard_d;
  ifid_t id_q, id_d;

  logic  skid_full, skid_load, skid_drain;
  word_t skid_inst, skid_pc;

  logic  resp_vld, resp_used, req, accept;
  word_t tgt, addr;

  // Memory answers exactly one cycle after the grant, so pend_q also means
  // "the response is on imem_rdata right now".
  always_comb begin
    tgt       = {redirect_target_i[31:2], 2'b00};
    resp_vld  = pend_q && !pend_discard_q;
    resp_used = resp_vld && !stall_i;
    req       = !rst && !skid_full && (!pend_q || resp_used || redirect_valid_i);
    addr      = redirect_valid_i ? tgt : fetch_pc_q;
    accept    = req && bus.imem_ready;
  end

  // A response goes to the skid only when decode cannot take it. It drains
  // ahead of any new response. No new response can exist while the skid is
  // full, because requests are blocked then.
  assign skid_load  = resp_vld && stall_i;
  assign skid_drain = skid_full && !stall_i;

  always_comb begin
    fetch_pc_d     = fetch_pc_q;
    pend_d         = accept;
    pend_pc_d      = pend_pc_q;
    pend_discard_d = pend_discard_q;
    id_d           = id_q;

    if (accept) begin
      pend_pc_d      = addr;
      fetch_pc_d     = addr + 32'd4;   // wraps FFFF_FFFC -> 0
      pend_discard_d = 1'b0;
    end else if (redirect_valid_i) begin
      // The target was not granted. Retry it from fetch_pc next cycle, and
      // keep any older request from ever being consumed.
      fetch_pc_d     = tgt;
      pend_discard_d = 1'b1;
    end

    if (redirect_valid_i) begin
      id_d = ifid_bubble(NOP_INST);
    end else if (stall_i) begin
      id_d = id_q;
    end else if (skid_full) begin
      id_d = '{valid: 1'b1, pc: skid_pc, pc4: skid_pc + 32'd4, inst: skid_inst};
    end else if (resp_vld) begin
      id_d = '{valid: 1'b1, pc: pend_pc_q, pc4: pend_pc_q + 32'd4, inst: bus.imem_rdata};
    end else begin
      id_d.valid = 1'b0;               // nothing arrived: bubble
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q     <= RESET_PC;
      pend_q         <= 1'b0;
      pend_pc_q      <= '0;
      pend_discard_q <= 1'b0;
      id_q           <= ifid_bubble(NOP_INST);
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      pend_q         <= pend_d;
      pend_pc_q      <= pend_pc_d;
      pend_discard_q <= pend_discard_d;
      id_q           <= id_d;
    end
  end

  if_skid_buffer u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear_i (redirect_valid_i),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .inst_i  (bus.imem_rdata),
    .pc_i    (pend_pc_q),
    .full_o  (skid_full),
    .inst_o  (skid_inst),
    .pc_o    (skid_pc)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = addr;
  assign bus.id_valid  = id_q.valid;
  assign bus.id_pc     = id_q.pc;
  assign bus.id_pc4    = id_q.pc4;
  assign bus.id_inst   = id_q.inst;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_tgt = '0;

  int errors = 0;
  int checks = 0;
  int acc10  = 0;
  logic last_stall = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  if_fetch_unit_if bus();

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall),
    .redirect_valid_i  (redir),
    .redirect_target_i (redir_tgt),
    .bus               (bus)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0:   mem_rd = 32'h0050_0093;
      32'h4:   mem_rd = 32'h0070_0113;
      32'h8:   mem_rd = 32'h0020_81B3;
      default: mem_rd = a ^ 32'h5EED_0001;
    endcase
  endfunction

  // Memory model: data one cycle after the grant, garbage otherwise.
  always @(posedge clk) begin
    last_stall <= stall;
    if (bus.imem_req && bus.imem_ready) begin
      bus.imem_rdata <= mem_rd(bus.imem_addr);
      if (bus.imem_addr == 32'h10) acc10 <= acc10 + 1;
    end else begin
      bus.imem_rdata <= $urandom;
    end
  end

  task automatic push(input logic [31:0] pc);
    exp_q.push_back('{pc, mem_rd(pc)});
  endtask

  // Advance to the next falling edge. Every freshly loaded IF/ID entry is
  // compared against the head of the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.id_valid === 1'b1 && !last_stall) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got pc=%h inst=%h, required no new instruction", bus.id_pc, bus.id_inst);
      end else begin
        e = exp_q.pop_front();
        if (bus.id_pc !== e.pc || bus.id_pc4 !== e.pc + 32'd4 || bus.id_inst !== e.inst) begin
          errors++;
          $display("FAIL sb_ifid got pc=%h pc4=%h inst=%h, required pc=%h pc4=%h inst=%h",
                   bus.id_pc, bus.id_pc4, bus.id_inst, e.pc, e.pc + 32'd4, e.inst);
        end
      end
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; stall = 1'b0; redir = 1'b0; bus.imem_ready = 1'b1;
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick(); #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b required 0", bus.imem_req); end
    checks++;
    if ({bus.id_valid, bus.id_pc, bus.id_pc4, bus.id_inst} !== {1'b0, 32'h0, 32'h0, 32'h13}) begin
      errors++;
      $display("FAIL rst_ifid got v=%b pc=%h pc4=%h inst=%h required 0/0/0/00000013", bus.id_valid, bus.id_pc, bus.id_pc4, bus.id_inst);
    end
    tick(); rst = 1'b0; push(32'h0); #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got req=%b addr=%h required 1/0", bus.imem_req, bus.imem_addr); end
    tick();
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL lat_early got valid=%b required 0", bus.id_valid); end
    tick();
    checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL lat_first got valid=%b required 1", bus.id_valid); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reset_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_stream();
    reset_dut();
    push(32'h0); push(32'h4); push(32'h8);
    repeat (4) tick();
    checks++; if (bus.id_pc4 !== 32'hC || bus.id_inst !== 32'h0020_81B3) begin errors++; $display("FAIL stream_pc8 got pc4=%h inst=%h required 0000000c/002081b3", bus.id_pc4, bus.id_inst); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    reset_dut();
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    repeat (3) tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h4) begin errors++; $display("FAIL stall_hold got v=%b pc=%h required 1/4", bus.id_valid, bus.id_pc); end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_noreq got %b required 0", bus.imem_req); end
    end
    tick(); stall = 1'b0; #1;
    checks++; if (bus.id_pc !== 32'h4) begin errors++; $display("FAIL stall_last got pc=%h required 4", bus.id_pc); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL drain_noreq got %b required 0", bus.imem_req); end
    tick(); #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin errors++; $display("FAIL resume_addr got req=%b addr=%h required 1/c", bus.imem_req, bus.imem_addr); end
    tick();
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL drain_bubble got %b required 0", bus.id_valid); end
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    reset_dut();
    push(32'h0); push(32'h4); push(32'h8); push(32'h40); push(32'h44);
    repeat (4) tick();
    redir = 1'b1; redir_tgt = 32'h43; #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin errors++; $display("FAIL redir_req got req=%b addr=%h required 1/40", bus.imem_req, bus.imem_addr); end
    tick(); redir = 1'b0; #1;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_inst !== 32'h13 || bus.id_pc !== 32'h0) begin
      errors++; $display("FAIL flush_bubble got v=%b inst=%h pc=%h required 0/00000013/0", bus.id_valid, bus.id_inst, bus.id_pc);
    end
    tick(); tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL redir_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_redirect_skid();
    reset_dut();
    push(32'h0); push(32'h4); push(32'h80);
    repeat (3) tick();
    stall = 1'b1;
    tick(); tick();
    redir = 1'b1; redir_tgt = 32'h80; #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rskid_noreq got %b required 0", bus.imem_req); end
    tick(); redir = 1'b0; stall = 1'b0; #1;
    checks++; if (bus.id_valid !== 1'b0 || bus.id_inst !== 32'h13) begin errors++; $display("FAIL rskid_bubble got v=%b inst=%h required 0/00000013", bus.id_valid, bus.id_inst); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80) begin errors++; $display("FAIL rskid_req got req=%b addr=%h required 1/80", bus.imem_req, bus.imem_addr); end
    tick();
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rskid_wait got %b required 0", bus.id_valid); end
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rskid_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int a0;
    reset_dut();
    a0 = acc10;
    push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h10); push(32'h14);
    repeat (4) tick();
    bus.imem_ready = 1'b0; #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin errors++; $display("FAIL bp_req got req=%b addr=%h required 1/10", bus.imem_req, bus.imem_addr); end
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin errors++; $display("FAIL bp_hold got req=%b addr=%h required 1/10", bus.imem_req, bus.imem_addr); end
      if (i > 0) begin
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL bp_bubble got %b required 0", bus.id_valid); end
      end
    end
    tick(); bus.imem_ready = 1'b1;
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL bp_bubble_end got %b required 0", bus.id_valid); end
    repeat (3) tick();
    checks++; if (acc10 - a0 != 1) begin errors++; $display("FAIL bp_single_fetch got %0d grants required 1", acc10 - a0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    push(32'h0); push(32'h4);
    repeat (3) tick();
    stall = 1'b1;
    tick(); rst = 1'b1; stall = 1'b0; #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rmid_req got %b required 0", bus.imem_req); end
    tick(); #1;
    checks++;
    if ({bus.id_valid, bus.id_pc, bus.id_pc4, bus.id_inst} !== {1'b0, 32'h0, 32'h0, 32'h13}) begin
      errors++; $display("FAIL rmid_ifid got v=%b pc=%h pc4=%h inst=%h required 0/0/0/00000013", bus.id_valid, bus.id_pc, bus.id_pc4, bus.id_inst);
    end
    tick(); rst = 1'b0; push(32'h0); push(32'h4); #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_restart got req=%b addr=%h required 1/0", bus.imem_req, bus.imem_addr); end
    tick();
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale got %b required 0", bus.id_valid); end
    tick(); tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    reset_dut();
    redir = 1'b1; redir_tgt = 32'hFFFF_FFFF;
    push(32'hFFFF_FFFC); push(32'h0); #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got req=%b addr=%h required 1/fffffffc", bus.imem_req, bus.imem_addr); end
    tick(); redir = 1'b0; #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got req=%b addr=%h required 1/0", bus.imem_req, bus.imem_addr); end
    tick();
    checks++; if (bus.id_pc !== 32'hFFFF_FFFC || bus.id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got pc=%h pc4=%h required fffffffc/0", bus.id_pc, bus.id_pc4); end
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain got %0d left required 0", exp_q.size()); end
  endtask

  initial begin
    bus.imem_ready = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_skid();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, required bench to finish");
    $fatal(1, "watchdog");
  end

endmodule
